// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary decoder.
package rotary_pkg;

    // Quadrature phase as {A,B}; clockwise order is 11 -> 10 -> 00 -> 01 -> 11.
    typedef enum logic [1:0] {
        PH_11 = 2'b11,
        PH_10 = 2'b10,
        PH_00 = 2'b00,
        PH_01 = 2'b01
    } phase_t;

    localparam int               SPEED_W   = 5;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 5'd31;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/rotary_decoder_if.sv
// Encoder-side inputs and paddle-side event outputs of the rotary decoder.
interface rotary_decoder_if;
    import rotary_pkg::*;

    logic               rot_a;
    logic               rot_b;
    logic               enable;
    logic               rotary_event;
    logic               rotary_right;
    logic [SPEED_W-1:0] speed;

    modport master (
        output rot_a, rot_b, enable,
        input  rotary_event, rotary_right, speed
    );

    modport slave (
        input  rot_a, rot_b, enable,
        output rotary_event, rotary_right, speed
    );

endinterface

// File: rtl/rotary_filter.sv
// One encoder channel: 2-FF synchroniser followed by a hold-time debouncer.
module rotary_filter #(
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // sync_p1 -> filtered: any return to the accepted level restarts the hold count
    always_ff @(posedge clock) begin
        if (reset) begin
            filtered <= 1'b1;
            cnt      <= '0;
        end else if (sync_p1 == filtered) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filtered <= sync_p1;
            cnt      <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature decoder: one event per detent with direction and speed.
// Define ROTARY_ACCEL_EN to derive speed from the interval between detents.
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int TICK_CYCLES     = 50000,
    parameter int MIN_SPEED       = 1
) (
    input logic             clock,
    input logic             reset,
    rotary_decoder_if.slave bus
);

    localparam logic [SPEED_W-1:0] SPEED_MIN = SPEED_W'(MIN_SPEED);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (TICK_CYCLES < 1) begin : g_bad_tick
        $error("TICK_CYCLES must be at least 1");
    end
    if (MIN_SPEED < 0 || MIN_SPEED > 31) begin : g_bad_speed
        $error("MIN_SPEED must be within 0..31");
    end

    logic a_filt;
    logic b_filt;

    rotary_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
        .clock    (clock),
        .reset    (reset),
        .raw      (bus.rot_a),
        .filtered (a_filt)
    );

    rotary_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
        .clock    (clock),
        .reset    (reset),
        .raw      (bus.rot_b),
        .filtered (b_filt)
    );

    phase_t             phase;
    phase_t             phase_nxt;
    logic               fire;
    logic               dir;
    logic [SPEED_W-1:0] speed_evt;
    logic               event_q;
    logic               right_q;
    logic [SPEED_W-1:0] speed_q;

    always_ff @(posedge clock) begin
        if (reset) phase <= PH_11;
        else       phase <= phase_nxt;
    end

    // A two-bit jump into 00 comes from 11, so only legal single-bit entries fire
    always_comb begin
        phase_nxt = phase_t'({a_filt, b_filt});
        fire      = 1'b0;
        dir       = DIR_CCW;
        if (bus.enable && phase_nxt == PH_00) begin
            case (phase)
                PH_10: begin
                    fire = 1'b1;
                    dir  = DIR_CW;
                end
                PH_01: begin
                    fire = 1'b1;
                    dir  = DIR_CCW;
                end
                default: ;
            endcase
        end
    end

`ifdef ROTARY_ACCEL_EN
    localparam int               PRE_W    = $clog2(TICK_CYCLES + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    logic [PRE_W-1:0]   presc;
    logic [SPEED_W-1:0] tick;
    logic [SPEED_W-1:0] tick_adv;
    logic               tick_step;
    logic               last_dir;

    function automatic logic [SPEED_W-1:0] sat_tick(input logic [SPEED_W-1:0] t,
                                                     input logic               step);
        return (step && t != SPEED_MAX) ? t + SPEED_W'(1) : t;
    endfunction

    function automatic logic [SPEED_W-1:0] floor_speed(input logic [SPEED_W-1:0] t);
        logic [SPEED_W-1:0] s;
        s = SPEED_MAX - t;
        return (s < SPEED_MIN) ? SPEED_MIN : s;
    endfunction

    assign tick_step = (presc == PRE_LAST);
    assign tick_adv  = sat_tick(tick, tick_step);

    // The event clock itself counts toward the interval it closes
    always_ff @(posedge clock) begin
        if (reset) begin
            presc    <= '0;
            tick     <= '0;
            last_dir <= DIR_CCW;
        end else if (fire) begin
            presc    <= '0;
            tick     <= '0;
            last_dir <= dir;
        end else begin
            presc <= tick_step ? '0 : presc + PRE_W'(1);
            tick  <= tick_adv;
        end
    end

    assign speed_evt = (dir != last_dir) ? SPEED_MIN : floor_speed(tick_adv);
`else
    assign speed_evt = SPEED_MIN;
`endif

    // Detent decision -> registered event/direction/speed
    always_ff @(posedge clock) begin
        if (reset) begin
            event_q <= 1'b0;
            right_q <= DIR_CCW;
            speed_q <= SPEED_MIN;
        end else begin
            event_q <= fire;
            if (fire) begin
                right_q <= dir;
                speed_q <= speed_evt;
            end
        end
    end

    assign bus.rotary_event = event_q;
    assign bus.rotary_right = right_q;
    assign bus.speed        = speed_q;

endmodule
